mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-owner sequencer for the shared 32-bit synchronous RAM (64K words, registered outputs, rw code 00 = fetch, 01 = read, 1x = write).
- Arbitrates between the instruction-fetch port and the load/store data port. Drives one RAM access at a time, captures the RAM's registered result, and returns it with a one-cycle ack.
- Sits between the core's fetch/LSU front-ends and the RAM instance; nothing else drives RAM pins.

Parameters:
- ADDR_W, 16, significant word-address bits; RAM address is this value zero-extended to 32 bits.
- DATA_W, 32, data width; must match the RAM.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch word address; stable while if_req.
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction; holds until next fetch ack.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load; stable while d_req.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle pulse: load/store complete.
- d_rdata  out  DATA_W  load data; valid with d_ack on loads, holds otherwise.
- ram_en  out  1  RAM enable.
- ram_rw  out  2  RAM access code.
- ram_addr  out  32  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_fetch  in  DATA_W  RAM instruction-fetch register output.
- ram_dout  in  DATA_W  RAM data-read register output (Z when RAM disabled).

Behaviour:
- Reset values: all outputs 0 (ram_rw = 2'b00, ram_en = 0, acks 0, rdata 0). Internal owner flag = none. FSM = IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states are IDLE → ISSUE → CAPTURE → DONE → IDLE.
- IDLE:
  - Sample if_req and d_req.
  - If neither is set, stay in IDLE.
  - Otherwise pick a winner, latch its address, we and wdata, and load the RAM outputs for the next cycle: ram_en = 1; ram_rw = 00 for fetch, 01 for load, 10 for store.
  - Go to ISSUE.
- ISSUE: ram_en = 1 for exactly this cycle; the RAM performs the access at the ending edge. Go to CAPTURE.
- CAPTURE:
  - ram_en = 0, ram_rw = 00, and ram_addr and ram_din hold.
  - At the ending edge, latch ram_fetch into if_rdata (fetch) or ram_dout into d_rdata (load); stores latch nothing.
  - Assert the winner's ack for the next cycle. Go to DONE.
- DONE: winner's ack = 1 for this cycle only. No arbitration happens here. Go to IDLE.
- Latency: request sampled in IDLE at cycle n gives ack high in cycle n+3. Peak throughput is one access per 4 cycles.
- Requester rules:
  - A requester must keep req high and its fields stable until it sees its ack.
  - A requester may drop req or present a new request in the cycle after ack.
  - A req dropped before ack is a protocol violation; the arbiter completes the access regardless.
- Default arbitration is strict priority: data beats fetch on a simultaneous request in IDLE.
- Simultaneous events:
  - A request arriving during ISSUE, CAPTURE or DONE waits; it is not sampled until IDLE.
  - The loser of arbitration stays pending and is re-evaluated in the next IDLE.
- Address width: ram_addr[31:ADDR_W] is always 0, and address bits above ADDR_W are never taken from requesters.
- rdata registers change only on their own port's read capture. A store never alters d_rdata.
- Reset mid-operation: outputs and FSM return to reset values immediately, and no ack is issued for the interrupted access. A store whose ISSUE edge has already passed is committed in the RAM; otherwise it is not.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- Defined: round-robin arbitration on simultaneous requests. A 1-bit last-winner register (reset = fetch) selects the port that did not win last; a lone requester always wins.
- Undefined: strict data priority as described in Behaviour. Fetch can starve under continuous d_req.

Test Plan:
- Reset: rst_n low mid-ISSUE of a store → outputs 0 immediately, state IDLE, no d_ack after release.
- Lone fetch: if_req=1, if_addr=0x0010, RAM[0x10]=0xE3A01005 → ram_en high for 1 cycle with ram_rw=00 and ram_addr=0x00000010; if_ack 3 cycles after sample, with if_rdata=0xE3A01005.
- Store then load: d_we=1, d_addr=0x0200, d_wdata=0xDEADBEEF, then d_we=0 at the same address → ram_rw=10 then 01; load d_ack with d_rdata=0xDEADBEEF; d_rdata unchanged across the store ack.
- Simultaneous requests with macro undefined: if_req and d_req high in the same cycle → data access first, fetch next (acks 4 cycles apart). With continuous d_req, no if_ack in 100 cycles.
- Simultaneous requests with MEM_ARB_FAIR_EN defined, both held continuously → acks alternate data, fetch, data, fetch…, starting with data (last winner resets to fetch).
- Back-to-back: new if_req presented in the cycle after if_ack → accepted in that IDLE; next if_ack 4 cycles after the previous one; ram_addr[31:16] = 0 throughout.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-owner sequencer for the shared 32-bit synchronous RAM.
// Arbitrates instruction fetch against load/store, runs one RAM access at a
// time through IDLE -> ISSUE -> CAPTURE -> DONE and returns the result with a
// one-cycle ack. All outputs are registered.
// Optional build macro: MEM_ARB_FAIR_EN selects round-robin arbitration on
// simultaneous requests; when undefined, data strictly beats fetch.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_en,
  output logic [1:0]        ram_rw,
  output logic [31:0]       ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_fetch,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } state_t;

  localparam logic [1:0] RW_FETCH = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  state_t state_r;
  logic   owner_r;     // 1 = data port owns the current access, 0 = fetch
  logic   we_r;        // latched store flag of the current data access
  logic   grant_d_s;   // data port wins the arbitration in this IDLE cycle

`ifdef MEM_ARB_FAIR_EN
  logic   last_r;      // last winner: 1 = data, 0 = fetch

  // Round-robin: on a tie the port that did not win last goes; lone requester wins
  always_comb begin
    grant_d_s = 1'b0;
    if (d_req && if_req) begin
      grant_d_s = ~last_r;
    end else begin
      grant_d_s = d_req;
    end
  end
`else
  // Strict priority: any pending data request beats fetch
  always_comb begin
    grant_d_s = 1'b0;
    if (d_req) begin
      grant_d_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
    end
  end
`endif

  // Access sequencer: arbitration, RAM drive, result capture and acks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      owner_r  <= 1'b0;
      we_r     <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
      last_r   <= 1'b0;
`endif
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= {DATA_W{1'b0}};
      d_rdata  <= {DATA_W{1'b0}};
      ram_en   <= 1'b0;
      ram_rw   <= RW_FETCH;
      ram_addr <= 32'h0000_0000;
      ram_din  <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (if_req || d_req) begin
            owner_r <= grant_d_s;
            ram_en  <= 1'b1;
`ifdef MEM_ARB_FAIR_EN
            last_r  <= grant_d_s;
`endif
            if (grant_d_s) begin
              we_r     <= d_we;
              ram_addr <= {{(32-ADDR_W){1'b0}}, d_addr};
              ram_din  <= d_wdata;
              ram_rw   <= d_we ? RW_WRITE : RW_READ;
            end else begin
              we_r     <= 1'b0;
              ram_addr <= {{(32-ADDR_W){1'b0}}, if_addr};
              ram_rw   <= RW_FETCH;
            end
            state_r <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          // RAM performs the access at the edge ending this cycle
          ram_en  <= 1'b0;
          ram_rw  <= RW_FETCH;
          state_r <= CAPTURE;
        end
        CAPTURE: begin
          // RAM registered outputs now hold the result of the access
          if (owner_r) begin
            if (!we_r) begin
              d_rdata <= ram_dout;
            end else begin
              d_rdata <= d_rdata;
            end
            d_ack <= 1'b1;
          end else begin
            if_rdata <= ram_fetch;
            if_ack   <= 1'b1;
          end
          state_r <= DONE;
        end
        DONE: begin
          if_ack  <= 1'b0;
          d_ack   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          if_ack  <= 1'b0;
          d_ack   <= 1'b0;
          ram_en  <= 1'b0;
          ram_rw  <= RW_FETCH;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table-driven bench for mem_arbiter with a
// behavioural registered-output RAM model, plus hand-written sequences for
// reset mid-access, simultaneous requests and fetch starvation/alternation.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        ram_en;
  logic [1:0]  ram_rw;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_fetch;
  logic [31:0] ram_dout;

  logic [31:0] mem [0:65535];

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model_i = 32'h0;
  logic [31:0] model_d = 32'h0;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  mem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_fetch(ram_fetch), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered fetch/read outputs, write on rw = 1x
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_rw[1]) mem[ram_addr[15:0]] <= ram_din;
      else if (ram_rw[0]) ram_dout <= mem[ram_addr[15:0]];
      else ram_fetch <= mem[ram_addr[15:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered just after a rising edge with the DUT idle; returns likewise
  task automatic run_vec(input vec_t v);
    int cnt;
    bit got;
    logic [1:0] exp_rw;
    exp_rw = v.is_d ? (v.we ? 2'b10 : 2'b01) : 2'b00;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 20) begin
      @(negedge clk);
      chk("addr_hi", {16'h0, ram_addr[31:16]}, 32'h0);
      if (cnt == 1) begin
        chk("en_issue", {31'h0, ram_en}, 32'h1);
        chk("rw_issue", {30'h0, ram_rw}, {30'h0, exp_rw});
        chk("addr_issue", ram_addr, {16'h0, v.addr});
      end
      if (cnt == 2) chk("en_capture", {31'h0, ram_en}, 32'h0);
      if (v.is_d ? d_ack : if_ack) begin
        got = 1'b1;
      end else begin
        @(posedge clk); #1;
        cnt++;
      end
    end
    chk("latency", cnt, 32'd3);
    chk("other_ack", {31'h0, v.is_d ? if_ack : d_ack}, 32'h0);
    if (v.is_d) begin
      if (!v.we) model_d = v.exp;
    end else begin
      model_i = v.exp;
    end
    chk("d_rdata", d_rdata, model_d);
    chk("if_rdata", if_rdata, model_i);
    @(posedge clk); #1;
    d_req = 1'b0;
    if_req = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 32'h0, 32'hE3A01005};
    vecs[1] = '{1'b1, 1'b1, 16'h0200, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 16'h0200, 32'h0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 16'h0200, 32'h12345678, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 16'h0200, 32'h0, 32'h12345678};
    vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 32'h0, 32'hA5A50001};
    vecs[6] = '{1'b1, 1'b1, 16'hFFFF, 32'h0BADF00D, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 16'hFFFF, 32'h0, 32'h0BADF00D};
    vecs[8] = '{1'b0, 1'b0, 16'h0010, 32'h0, 32'hE3A01005};
    vecs[9] = '{1'b0, 1'b0, 16'h0011, 32'h0, 32'h00C0FFEE};

    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    mem[16'h0010] = 32'hE3A01005;
    mem[16'h0011] = 32'h00C0FFEE;
    mem[16'hFFFF] = 32'hA5A50001;
    ram_fetch = 32'h0;
    ram_dout  = 32'h0;

    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 16'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", {31'h0, ram_en}, 32'h0);
    chk("rst_rw", {30'h0, ram_rw}, 32'h0);
    chk("rst_addr", ram_addr, 32'h0);
    chk("rst_acks", {30'h0, if_ack, d_ack}, 32'h0);
    chk("rst_rdata", if_rdata | d_rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven single accesses, each presented in the cycle after the previous ack
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset while a store is in ISSUE: no commit, no ack, outputs cleared
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0300; d_wdata = 32'h55AA55AA;
    @(posedge clk); #2;
    chk("issue_en_pre_rst", {31'h0, ram_en}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_en", {31'h0, ram_en}, 32'h0);
    chk("midrst_rw", {30'h0, ram_rw}, 32'h0);
    chk("midrst_addr", ram_addr, 32'h0);
    chk("midrst_din", ram_din, 32'h0);
    chk("midrst_rdata", if_rdata | d_rdata, 32'h0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("midrst_no_ack", {30'h0, if_ack, d_ack}, 32'h0);
    end
    chk("midrst_no_commit", mem[16'h0300], 32'h0);
    model_i = 32'h0;
    model_d = 32'h0;
    @(posedge clk); #1;
    run_vec(vecs[0]);

    // Simultaneous fetch and load: data first, fetch 4 cycles later
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    if_req = 1'b1; if_addr = 16'h0010;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("sim_d_ack", {31'h0, d_ack}, {31'h0, c == 3});
      chk("sim_if_ack", {31'h0, if_ack}, {31'h0, c == 7});
      if (c == 3) chk("sim_d_rdata", d_rdata, 32'h12345678);
      if (c == 7) chk("sim_if_rdata", if_rdata, 32'hE3A01005);
      @(posedge clk); #1;
      if (c == 3) d_req = 1'b0;
      if (c == 7) if_req = 1'b0;
    end

    // Both requests held continuously for 100 cycles
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    if_req = 1'b1; if_addr = 16'h0011;
    begin
      int n_if;
      n_if = 0;
      for (int c = 0; c < 100; c++) begin
        logic slot, exp_d, exp_i;
        slot = ((c % 4) == 3);
`ifdef MEM_ARB_FAIR_EN
        exp_d = slot && (((c / 4) % 2) == 0);
        exp_i = slot && (((c / 4) % 2) == 1);
`else
        exp_d = slot;
        exp_i = 1'b0;
`endif
        @(negedge clk);
        chk("cont_d_ack", {31'h0, d_ack}, {31'h0, exp_d});
        chk("cont_if_ack", {31'h0, if_ack}, {31'h0, exp_i});
        if (if_ack) n_if++;
        @(posedge clk); #1;
      end
`ifndef MEM_ARB_FAIR_EN
      chk("starve_if_acks", n_if, 32'd0);
`else
      chk("fair_if_acks", n_if, 32'd12);
`endif
    end
    d_req = 1'b0;
    if_req = 1'b0;
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
